// File: rtl/clk_div_bank.sv
// Fully synchronous timebase: binary tap divider plus a programmable divide-by-N
// whose divisor is only swapped at period boundaries, so no runt pulses appear.
module clk_div_bank #(
  parameter int STAGES = 5,
  parameter int PDIV_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic [STAGES-1:0] div_out,
  output logic [STAGES-1:0] tick,
  input  logic [PDIV_W-1:0] pdiv_n,
  input  logic              pdiv_load,
  output logic              pdiv_busy,
  output logic              pdiv_out,
  output logic              pdiv_tick
);
  logic [STAGES-1:0] cnt_q, cnt_d, tick_q, tick_d;
  logic [PDIV_W-1:0] p_q, p_d, r_q, r_d, ph_q, ph_d;
  logic busy_q, busy_d, pout_q, pout_d, ptick_q, ptick_d;
  logic p_en_s, p_nxt_en_s, wrap_s, apply_s, adv_s;

  function automatic logic [STAGES-1:0] low_mask(input int k);
    low_mask = (STAGES'(1) << k) - STAGES'(1);
  endfunction

  // Binary counter next state and per-tap rising-edge ticks
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = '0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + STAGES'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // Tap k rises on the next edge when bit k is clear and every lower bit is set.
    for (int k = 0; k < STAGES; k++) begin
      if (en && !clr && (cnt_q[k] == 1'b0) && ((cnt_q & low_mask(k)) == low_mask(k))) begin
        tick_d[k] = 1'b1;
      end else begin
        tick_d[k] = 1'b0;
      end
    end
  end

  assign p_en_s  = |p_q[PDIV_W-1:1];
  assign wrap_s  = (ph_q == (p_q - PDIV_W'(1)));
  assign apply_s = busy_q & (~p_en_s | clr | (en & wrap_s));
  assign adv_s   = en | apply_s;

  // Programmable divider: load handshake, boundary apply, phase and outputs
  always_comb begin
    p_d     = p_q;
    r_d     = r_q;
    busy_d  = busy_q;
    ph_d    = ph_q;
    pout_d  = pout_q;
    ptick_d = 1'b0;
    if (apply_s) begin
      p_d    = r_q;
      ph_d   = '0;
      busy_d = 1'b0;
    end else begin
      if (pdiv_load && !busy_q) begin
        r_d    = pdiv_n;
        busy_d = 1'b1;
      end else begin
        r_d    = r_q;
        busy_d = busy_q;
      end
      if (clr || !p_en_s) begin
        ph_d = '0;
      end else if (en) begin
        ph_d = wrap_s ? '0 : ph_q + PDIV_W'(1);
      end else begin
        ph_d = ph_q;
      end
    end
    p_nxt_en_s = |p_d[PDIV_W-1:1];
    // A plain clear forces the output low even though the phase restarts at 0.
    if (clr && !apply_s) begin
      pout_d  = 1'b0;
      ptick_d = 1'b0;
    end else if (adv_s) begin
      pout_d  = p_nxt_en_s && (ph_d < (p_d >> 1));
      ptick_d = p_nxt_en_s && (ph_d == '0);
    end else begin
      pout_d  = pout_q;
      ptick_d = 1'b0;
    end
  end

  // State registers; every output is taken straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tick_q  <= '0;
      p_q     <= '0;
      r_q     <= '0;
      ph_q    <= '0;
      busy_q  <= 1'b0;
      pout_q  <= 1'b0;
      ptick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      p_q     <= p_d;
      r_q     <= r_d;
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      pout_q  <= pout_d;
      ptick_q <= ptick_d;
    end
  end

  assign div_out   = cnt_q;
  assign tick      = tick_q;
  assign pdiv_busy = busy_q;
  assign pdiv_out  = pout_q;
  assign pdiv_tick = ptick_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed sequences, a vector table for the
// programmable divider, and randomized stimulus against a behavioural model.
module tb_clk_div_bank;
  localparam int STAGES = 5;
  localparam int PDIV_W = 16;

  logic clk, rst_n, en, clr, pdiv_load;
  logic [PDIV_W-1:0] pdiv_n;
  logic [STAGES-1:0] div_out, tick;
  logic pdiv_busy, pdiv_out, pdiv_tick;

  int checks, failures;

  int m_cnt, m_P, m_R, m_q;
  logic [STAGES-1:0] m_tick;
  bit m_busy, m_pout, m_ptick;

  typedef struct {
    bit en; bit clr; bit load; int n;
    bit busy; bit pout; bit ptick;
  } vec_t;
  vec_t vt[$];

  clk_div_bank #(.STAGES(STAGES), .PDIV_W(PDIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .div_out(div_out), .tick(tick),
    .pdiv_n(pdiv_n), .pdiv_load(pdiv_load),
    .pdiv_busy(pdiv_busy), .pdiv_out(pdiv_out), .pdiv_tick(pdiv_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_tick = '0; m_P = 0; m_R = 0; m_q = 0;
    m_busy = 1'b0; m_pout = 1'b0; m_ptick = 1'b0;
  endtask

  // Spec-level model: integer period position, modulo arithmetic, tap edges from bit compares.
  task automatic model_step();
    int old_c, new_c, nP, nq;
    bit apply, adv, nbusy;
    old_c = m_cnt;
    if (clr) new_c = 0;
    else if (en) new_c = (old_c + 1) % (1 << STAGES);
    else new_c = old_c;
    for (int k = 0; k < STAGES; k++) m_tick[k] = en && !clr && new_c[k] && !old_c[k];
    m_cnt = new_c;
    apply = m_busy && ((m_P < 2) || clr || (en && (m_q == m_P - 1)));
    adv = en || apply;
    if (apply) begin
      nP = m_R; nq = 0; nbusy = 1'b0;
    end else begin
      nP = m_P; nbusy = m_busy;
      if (pdiv_load && !m_busy) begin
        m_R = int'(pdiv_n); nbusy = 1'b1;
      end
      if (clr || (m_P < 2)) nq = 0;
      else if (en) nq = (m_q + 1) % m_P;
      else nq = m_q;
    end
    if (clr && !apply) begin
      m_pout = 1'b0; m_ptick = 1'b0;
    end else if (adv) begin
      m_pout = (nP >= 2) && (nq < nP / 2);
      m_ptick = (nP >= 2) && (nq == 0);
    end else begin
      m_ptick = 1'b0;
    end
    m_P = nP; m_q = nq; m_busy = nbusy;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("div_out", 32'(div_out), 32'(m_cnt));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("pdiv_busy", 32'(pdiv_busy), 32'(m_busy));
    chk("pdiv_out", 32'(pdiv_out), 32'(m_pout));
    chk("pdiv_tick", 32'(pdiv_tick), 32'(m_ptick));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_div_out"}, 32'(div_out), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_busy"}, 32'(pdiv_busy), 32'd0);
    chk({tag, "_pout"}, 32'(pdiv_out), 32'd0);
    chk({tag, "_ptick"}, 32'(pdiv_tick), 32'd0);
  endtask

  // Called just after an active edge: asynchronous reset pulse between edges.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; pdiv_load = 1'b0; pdiv_n = '0;
    #1;
    chk_zero(tag);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t v(bit e, bit c, bit l, int n, bit b, bit o, bit t);
    vec_t r;
    r.en = e; r.clr = c; r.load = l; r.n = n; r.busy = b; r.pout = o; r.ptick = t;
    return r;
  endfunction

  initial begin
    logic [STAGES-1:0] frozen;
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; pdiv_load = 1'b0; pdiv_n = '0;
    model_reset();
    #7;
    chk_zero("reset");
    #1;
    rst_n = 1'b1;

    // Reset mid-count: no clock edge needed for outputs to clear.
    en = 1'b1;
    pdiv_load = 1'b1; pdiv_n = PDIV_W'(5);
    cycle();
    pdiv_load = 1'b0;
    for (int i = 1; i < 13; i++) cycle();
    chk("count13", 32'(div_out), 32'd13);
    async_reset("midreset");

    // Binary taps with en held high from reset.
    en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      chk("tap4_level", 32'(div_out[4]), 32'((i % 32) >= 16));
      chk("tick2_pos", 32'(tick[2]), 32'((i % 8) == 4));
      chk("tick0_pos", 32'(tick[0]), 32'(i % 2));
    end
    frozen = div_out;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("freeze_div", 32'(div_out), 32'(frozen));
      chk("freeze_tick", 32'(tick), 32'd0);
    end
    chk("freeze_val", 32'(frozen), 32'd8);
    async_reset("pretable");

    // Programmable divider vectors: {en,clr,load,n | busy,pout,ptick} after each edge.
    vt.push_back(v(1,0,1,5, 1,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,1,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,1,0));
    vt.push_back(v(1,0,1,4, 1,0,0));
    vt.push_back(v(1,0,1,7, 1,0,0));
    vt.push_back(v(1,0,0,0, 1,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,1,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,1,1, 1,1,0));
    vt.push_back(v(1,0,0,0, 1,0,0));
    vt.push_back(v(1,0,0,0, 1,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,1,6, 1,0,0));
    vt.push_back(v(0,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,1,0));
    vt.push_back(v(1,0,1,3, 1,1,0));
    vt.push_back(v(1,1,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,1,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,1,2, 1,1,1));
    vt.push_back(v(1,0,0,0, 1,0,0));
    vt.push_back(v(1,0,0,0, 1,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    vt.push_back(v(1,0,0,0, 0,0,0));
    vt.push_back(v(0,0,0,0, 0,0,0));
    vt.push_back(v(1,0,0,0, 0,1,1));
    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; clr = vt[i].clr; pdiv_load = vt[i].load; pdiv_n = PDIV_W'(vt[i].n);
      cycle();
      chk($sformatf("vec%0d_busy", i), 32'(pdiv_busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d_pout", i), 32'(pdiv_out), 32'(vt[i].pout));
      chk($sformatf("vec%0d_ptick", i), 32'(pdiv_tick), 32'(vt[i].ptick));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      pdiv_load = ($urandom_range(0, 4) == 0);
      pdiv_n = ($urandom_range(0, 3) == 0) ? PDIV_W'($urandom_range(0, 40))
                                            : PDIV_W'($urandom_range(0, 9));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Fully synchronous divider bank for the frequency-meter timebase. Replaces ripple-clocked toggle chains; every flop sits on the single clk.
- Provides STAGES binary taps, each a 50% square wave at clk/2^(k+1), with a one-cycle tick pulse per tap.
- Adds one programmable divide-by-N output with glitch-free reload at period boundaries. Used for gate-time and reference generation.

Parameters:
- STAGES, 5, number of binary taps (clk/2 .. clk/2^STAGES); range 1..16.
- PDIV_W, 16, width of the programmable divisor.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable for both sections.
- clr  in  1  synchronous clear; priority over en.
- div_out  out  STAGES  binary taps; bit k = clk/2^(k+1), 50% duty.
- tick  out  STAGES  tick[k] high for one clk on each rising edge of div_out[k].
- pdiv_n  in  PDIV_W  requested divisor N.
- pdiv_load  in  1  load request for pdiv_n.
- pdiv_busy  out  1  load pending and not yet applied.
- pdiv_out  out  1  programmable divided output.
- pdiv_tick  out  1  one-cycle pulse at the start of each programmable period.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset: all state and all outputs clear to 0 immediately. div_out=0, tick=0, pdiv_out=0, pdiv_tick=0, pdiv_busy=0. Active divisor P=0, meaning the programmable section is disabled.
- Binary section:
  - STAGES-bit counter c; div_out = c, no combinational logic on the output.
  - clr=1: c<=0, tick<=0.
  - else en=1: c<=c+1, wrapping at 2^STAGES-1 -> 0.
  - else: c holds, tick<=0.
  - tick[k] <= en & ~clr & (c[k:0] == 2^k-1), so tick[k] is high in exactly the first cycle div_out[k] is 1.
  - After reset with en held at 1: div_out[0] toggles every edge; div_out[k] toggles every 2^k edges. Waveform equals a toggle-flop ripple chain, but with no skew.
- Programmable section state: P (active divisor), R (pending divisor), q (phase counter, PDIV_W bits), busy.
- Load handshake:
  - pdiv_load=1 with busy=0: R<=pdiv_n, busy<=1.
  - pdiv_load while busy=1 is ignored; R is not overwritten.
- Apply: the pending value is applied on the edge where any of the following holds:
  - (a) busy=1 and P<2 (disabled), or
  - (b) busy=1 and en=1 and q==P-1 (period end), or
  - (c) busy=1 and clr=1.
- On apply: P<=R, q<=0, busy<=0.
- Load and wrap in the same cycle with busy=0: R is captured, but it applies at the next period end, not the current one.
- P<2 (0 or 1) means disabled: q held at 0, pdiv_out=0, pdiv_tick=0.
- P>=2 and en=1 (no apply, no clr): q<=(q==P-1) ? 0 : q+1.
- P>=2 and en=0: q, pdiv_out hold; pdiv_tick<=0.
- clr without busy: q<=0, pdiv_out<=0, pdiv_tick<=0. P is kept.
- Outputs registered from next-state q' and P':
  - pdiv_out <= (P'>=2) & (q' < P'>>1).
  - pdiv_tick <= (P'>=2) & (q'==0) & advancing, where advancing means en=1 or an apply this edge.
- Duty: the output is high for floor(N/2) cycles and low for ceil(N/2) cycles. Period is exactly N clocks while en=1.
- The divisor never changes mid-period, so there are no runt pulses.
- Apply from the disabled state starts a period on the next edge. q'=0, so pdiv_tick and pdiv_out rise together.
- Width: q compares against P-1 in PDIV_W bits. N=2^PDIV_W-1 is the maximum legal divisor.

Test Plan:
- Reset mid-count: run en=1 for 13 clks, assert rst_n=0 between edges -> all outputs 0 immediately, with no clock required.
- Binary taps, STAGES=5, en=1 from reset: div_out[4] period 32 clks, high 16. tick[2] fires on cycles 4, 12, 20 after reset and coincides with div_out[2] 0->1. en low for 3 clks -> div_out frozen, tick=0.
- Programmable divider from reset: load N=5 -> busy for 1 cycle. pdiv_out pattern 1,1,0,0,0 repeating. pdiv_tick every 5 clks, aligned with the first high.
- Reload at boundary: running N=5, load N=4 at q=1 -> busy stays 1 until q==4. Next period is 1,1,0,0. A load of N=7 during busy is ignored.
- Disable and clr: load N=1 -> pdiv_out stays 0. Then clr with busy set -> pending applied immediately, q=0.
- Edge divisors: N=2 -> pdiv_out toggles every clk. N=3 -> 1,0,0. A simultaneous load and wrap defers the new N by one full period.
